// File: rtl/sram_like_arbiter.sv
// Merges the instruction-fetch and data sram-like ports onto one memory port, one transaction in flight.
// Optional build macro ARB_RR_EN selects round-robin arbitration; default is fixed data-over-inst priority.
module sram_like_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;

    // Handshake: a request is transferred on the cycle where req && addr_ok are both high;
    // the reply is transferred on the single cycle data_ok is high, rdata qualified by data_ok.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;
    logic   owner;       // 0 = inst, 1 = data
    logic   last_grant;  // 0 = inst, 1 = data

    logic   grant;
    logic   idle_live;
    logic   wait_live;
    logic   issue;
    logic   reply;

    // With no request pending the grant parks on the previous winner; it has no effect then.
    always_comb begin
        grant = last_grant;
`ifdef ARB_RR_EN
        if (inst_req && data_req) begin
            grant = ~last_grant;
        end else if (data_req) begin
            grant = 1'b1;
        end else if (inst_req) begin
            grant = 1'b0;
        end
`else
        if (data_req) begin
            grant = 1'b1;
        end else if (inst_req) begin
            grant = 1'b0;
        end
`endif
    end

    assign idle_live = (state == S_IDLE) && !rst;
    assign wait_live = (state == S_WAIT) && !rst;

    assign mem_req = idle_live && (inst_req || data_req);
    assign issue   = mem_req && mem_addr_ok;
    assign reply   = wait_live && mem_data_ok;

    // Memory-side request fields follow the granted master; a fetch never carries write data.
    always_comb begin
        mem_wr    = 1'b0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            if (grant) begin
                mem_wr    = data_wr;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_addr  = inst_addr;
            end
        end
    end

    always_comb begin
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        if (issue) begin
            if (grant) begin
                data_addr_ok = 1'b1;
            end else begin
                inst_addr_ok = 1'b1;
            end
        end
    end

    always_comb begin
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        if (reply) begin
            if (owner) begin
                data_data_ok = 1'b1;
            end else begin
                inst_data_ok = 1'b1;
            end
        end
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // A response arriving while idle (including after a reset abort) is simply ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state      <= S_WAIT;
                        owner      <= grant;
                        last_grant <= grant;
                    end
                end
                S_WAIT: begin
                    if (mem_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [STRB_W-1:0] unused_strb_w;
    assign unused_strb_w = '0;

endmodule
